// File: rtl/wordline_sequencer_if.sv
// Handshake and word-line bundle between the array controller and the
// word-line sequencer.
interface wordline_sequencer_if #(
    parameter int ADDR_W = 3
);
    localparam int WORDS = 1 << ADDR_W;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [ADDR_W-1:0] len;
    logic              ready;
    logic [WORDS-1:0]  sel_x;
    logic              wr_en;
    logic [ADDR_W-1:0] cur_adr;
    logic              done;

    modport master (
        output req, we, adr, len,
        input  ready, sel_x, wr_en, cur_adr, done
    );

    modport slave (
        input  req, we, adr, len,
        output ready, sel_x, wr_en, cur_adr, done
    );
endinterface

// File: rtl/wordline_sequencer.sv
// Registered word-line sequencer: one-hot timed pulses with
// break-before-make spacing and wrapping multi-word bursts.
module wordline_sequencer #(
    parameter int ADDR_W    = 3,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    wordline_sequencer_if.slave  bus
);
    localparam int WORDS     = 1 << ADDR_W;
    localparam int MAX_C     = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_adr_q, cur_adr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [WORDS-1:0]  sel_x_q, sel_x_d;
    logic              word_end;

    always_comb begin
        state_d   = state_q;
        cur_adr_d = cur_adr_q;
        rem_d     = rem_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        word_end  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    cur_adr_d = bus.adr;
                    rem_d     = bus.len;
                    we_d      = bus.we;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                    cnt_d = '0;
                    if (GAP_CYC > 0) begin
                        state_d = RECOVER;
                    end else begin
                        word_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    word_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address wraps naturally through the ADDR_W-bit adder.
        if (word_end) begin
            if (rem_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cur_adr_d = cur_adr_q + 1'b1;
                rem_d     = rem_q - 1'b1;
                state_d   = SETUP;
            end
        end

        sel_x_d = '0;
        wr_en_d = 1'b0;
        if (state_d == ACTIVE) begin
            sel_x_d = WORDS'(1) << cur_adr_d;
            wr_en_d = we_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_adr_q <= '0;
            rem_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            sel_x_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_adr_q <= cur_adr_d;
            rem_q     <= rem_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            sel_x_q   <= sel_x_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.sel_x   = sel_x_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.cur_adr = cur_adr_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_wordline_sequencer.sv
// Directed bench for wordline_sequencer with default timing
// (PULSE_CYC=2, GAP_CYC=1, per-word period 4).
module tb_wordline_sequencer;
    logic clk = 1'b0;
    logic rst;

    wordline_sequencer_if #(.ADDR_W(3)) bus ();

    wordline_sequencer #(
        .ADDR_W(3),
        .PULSE_CYC(2),
        .GAP_CYC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // {ready, done, wr_en, sel_x[7:0], cur_adr[2:0]}
    function automatic logic [13:0] obs();
        return {bus.ready, bus.done, bus.wr_en, bus.sel_x, bus.cur_adr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] a, input logic [2:0] l, input logic w);
        bus.req = 1'b1;
        bus.adr = a;
        bus.len = l;
        bus.we  = w;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        e = {1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
        rst = 1'b1;
        bus.req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_hold got=%h want=%h", obs(), e);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_release got=%h want=%h", obs(), e);
        end
    endtask

    task automatic test_single_read();
        logic [7:0]  s;
        logic [13:0] e;
        start(3'd5, 3'd0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            s = (c == 2 || c == 3) ? 8'h20 : 8'h00;
            e = {(c < 1 || c > 4), (c == 5), 1'b0, s, 3'd5};
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL single_read c=%0d got=%h want=%h", c, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0]  s;
        logic [2:0]  a;
        logic [13:0] e;
        start(3'd6, 3'd2, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            case (c)
                2, 3:    s = 8'h40;
                6, 7:    s = 8'h80;
                10, 11:  s = 8'h01;
                default: s = 8'h00;
            endcase
            a = (c <= 4) ? 3'd6 : (c <= 8) ? 3'd7 : 3'd0;
            e = {(c >= 13), (c == 13), (s != 8'h00), s, a};
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL burst_wrap c=%0d got=%h want=%h", c, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_busy_reject();
        logic [7:0]  s;
        logic [2:0]  a;
        logic [13:0] e;
        start(3'd0, 3'd1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            bus.req = (c == 3);
            bus.adr = (c == 3) ? 3'd2 : 3'd0;
            case (c)
                2, 3:    s = 8'h01;
                6, 7:    s = 8'h02;
                default: s = 8'h00;
            endcase
            a = (c <= 4) ? 3'd0 : 3'd1;
            e = {(c >= 9), (c == 9), 1'b0, s, a};
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL busy_reject c=%0d got=%h want=%h", c, obs(), e);
            end
            tick();
        end
        bus.req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s;
        logic [2:0]  a;
        logic        r;
        logic [13:0] e;
        bus.req = 1'b1;
        bus.adr = 3'd1;
        bus.len = 3'd0;
        bus.we  = 1'b0;
        tick();
        bus.adr = 3'd3;
        for (int c = 1; c <= 11; c++) begin
            if (c == 6) bus.req = 1'b0;
            case (c)
                2, 3:    s = 8'h02;
                7, 8:    s = 8'h08;
                default: s = 8'h00;
            endcase
            a = (c <= 5) ? 3'd1 : 3'd3;
            r = (c == 5 || c >= 10);
            e = {r, (c == 5 || c == 10), 1'b0, s, a};
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL back_to_back c=%0d got=%h want=%h", c, obs(), e);
            end
            tick();
        end
        bus.req = 1'b0;
    endtask

    task automatic test_full_sweep();
        int          hits [8];
        logic [7:0]  s;
        int          k;
        int          ph;
        for (int i = 0; i < 8; i++) hits[i] = 0;
        start(3'd3, 3'd7, 1'b1);
        for (int c = 1; c <= 34; c++) begin
            k  = (c - 1) / 4;
            ph = (c - 1) % 4;
            s  = 8'h00;
            if (c <= 32 && (ph == 1 || ph == 2)) s = 8'h01 << ((3 + k) % 8);
            for (int i = 0; i < 8; i++) if (bus.sel_x[i]) hits[i]++;
            n_cmp++;
            if ($countones(bus.sel_x) > 1 || bus.sel_x !== s ||
                bus.wr_en !== (s != 8'h00) || bus.done !== (c == 33)) begin
                n_bad++;
                $display("FAIL full_sweep c=%0d got sel=%h we=%b dn=%b want sel=%h dn=%b",
                         c, bus.sel_x, bus.wr_en, bus.done, s, (c == 33));
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (hits[i] != 2) begin
                n_bad++;
                $display("FAIL sweep_hits bit=%0d got=%0d want=2", i, hits[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] e;
        e = {1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
        start(3'd4, 3'd3, 1'b1);
        tick();
        n_cmp++;
        if (bus.sel_x !== 8'h10 || bus.wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_active got sel=%h we=%b want sel=10 we=1",
                     bus.sel_x, bus.wr_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset_abort c=%0d got=%h want=%h", c, obs(), e);
            end
            tick();
        end
        rst = 1'b1;
        bus.req = 1'b1;
        bus.adr = 3'd2;
        tick();
        rst = 1'b0;
        bus.req = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL rst_over_req got=%h want=%h", obs(), e);
        end
    endtask

    initial begin
        bus.req = 1'b0;
        bus.we  = 1'b0;
        bus.adr = '0;
        bus.len = '0;
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_busy_reject();
        test_back_to_back();
        test_full_sweep();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wordline_sequencer.md
# wordline_sequencer

Registered, parametrised successor to the combinational address decoder in the bitcell/NAND-latch memory array. It accepts a word-access request through a ready/req handshake and decodes the latched address into a one-hot word-line select. It drives the select as a timed pulse with break-before-make spacing, and supports multi-word bursts with address auto-increment and wrap-around. It sits between the array controller and the bitcell rows, replacing the direct `select`/`adr` decode path.

## Interface
- `ADDR_W`, 3: address width; the array has 2^ADDR_W word lines.
- `PULSE_CYC`, 2: cycles each word line is held high (legal range ≥1).
- `GAP_CYC`, 1: recovery cycles with all word lines low after each pulse (legal range ≥0; 0 skips RECOVER).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; sampled only when `ready`=1.
- `we`  in  1  1 = write access, 0 = read access; captured on accept.
- `adr`  in  ADDR_W  start word address; captured on accept.
- `len`  in  ADDR_W  burst length minus one (0 = single word); captured on accept.
- `ready`  out  1  high only in IDLE.
- `sel_x`  out  2^ADDR_W  one-hot word-line select; all zero outside ACTIVE.
- `wr_en`  out  1  equals the captured `we` during ACTIVE; 0 otherwise.
- `cur_adr`  out  ADDR_W  address of the word currently being sequenced.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, SETUP, ACTIVE, RECOVER.
- IDLE: `ready`=1. On `req`=1, the block latches `adr`→`cur_adr`, `we`, and `len`→remaining count, then moves to SETUP.
- SETUP: lasts exactly 1 cycle. `sel_x`=0 while the address settles. Next state is ACTIVE.
- ACTIVE: lasts PULSE_CYC cycles. `sel_x` = 1 << `cur_adr`; `wr_en` = latched `we`.
- RECOVER: lasts GAP_CYC cycles with `sel_x`=0.
  - If remaining = 0: go to IDLE and assert `done` for the first IDLE cycle.
  - Otherwise: `cur_adr` increments modulo 2^ADDR_W, remaining decrements, and the next state is SETUP.
- When GAP_CYC=0, ACTIVE exits directly with the same decision logic.
- Address wrap: 2^ADDR_W−1 + 1 = 0. There is no error and no stall.
- A burst of `len`=2^ADDR_W−1 visits every word exactly once.
- `req` outside IDLE is ignored. Inputs are not re-sampled mid-burst.
- `done` and `ready` are both high in the completion cycle. A `req` in that cycle is accepted, which gives back-to-back bursts with zero idle cycles.
- Invariant: at most one bit of `sel_x` is ever high. Between consecutive words there is always ≥1 cycle of `sel_x`=0 (the SETUP cycle).

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset (`rst`=1 at an edge): state=IDLE, `sel_x`=0, `wr_en`=0, `done`=0, `cur_adr`=0, `ready`=1 from the following cycle.
- Reset mid-operation (any state) aborts the burst: `sel_x`/`wr_en` drop at that edge, and no `done` is produced.
- `rst` has priority over `req` in the same cycle.
- Per-word period: 1 + PULSE_CYC + GAP_CYC cycles.
- Cycle numbering for bursts: the acceptance edge is cycle 0. For an N-word burst:
  - word k is in SETUP at cycle 1 + k·P, where P is the per-word period;
  - word k is in ACTIVE for cycles 2 + k·P … 1 + k·P + PULSE_CYC;
  - `done` is high at cycle 1 + N·P.
- With defaults: P = 4, and a single word gives ACTIVE in cycles 2–3, RECOVER in cycle 4, and `done` in cycle 5.

## Test plan
- Reset: hold `rst` 2 cycles from X → `sel_x`=8'h00, `wr_en`=0, `done`=0, `cur_adr`=0, `ready`=1. Repeat `rst` during ACTIVE → `sel_x`=0 next cycle, no `done`, `ready`=1.
- Single read, `adr`=5, `len`=0, `we`=0 → `sel_x`=8'h20 in cycles 2–3, `wr_en`=0 throughout, `ready`=0 in cycles 1–4, `done`=1 in cycle 5 only.
- Burst write with wrap, `adr`=6, `len`=2, `we`=1 → `sel_x`=8'h40 in cycles 2–3, 8'h80 in cycles 6–7, 8'h01 in cycles 10–11; `wr_en`=1 exactly in those cycles; `sel_x`=0 in cycles 4–5 and 8–9; `done` in cycle 13.
- Busy rejection: pulse `req` with `adr`=2 in cycle 3 of a burst started at `adr`=0 → 8'h04 never appears, and `cur_adr` follows the original burst.
- Back-to-back: hold `req`=1 with `adr`=1 then `adr`=3 → second burst accepted in the `done` cycle (cycle 5), 8'h08 in cycles 7–8, no idle gap beyond SETUP.
- Full sweep: `len`=7, `adr`=3 → each of 8'h08, 8'h10, …, 8'h04 high exactly once, one-hot checked every cycle, `done` in cycle 33.
